// File: rtl/rv32i_instruction_decoder.sv
// RV32I decode stage: combinational field/control decode plus a sticky
// illegal-instruction flag that latches until reset.
module rv32i_instruction_decoder (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR,
    output logic [4:0]  alu_instruction,
    output logic [31:0] immediate_value,
    output logic [2:0]  instruction_format_type,
    output logic [1:0]  write_back_type,
    output logic [1:0]  read_status,
    output logic [1:0]  write_status,
    output logic        load_signed,
    output logic [4:0]  destination_register_number,
    output logic        pc_for_input_a,
    output logic        change_branch_instruction,
    output logic        illegal_instruction
);
    localparam logic [4:0] ALU_ADD = 5'd0,  ALU_SUB = 5'd1,  ALU_SLL = 5'd2,  ALU_SLT = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4, ALU_XOR = 5'd5,  ALU_SRL = 5'd6,  ALU_SRA = 5'd7;
    localparam logic [4:0] ALU_OR = 5'd8,   ALU_AND = 5'd9,  ALU_BEQ = 5'd10, ALU_BNE = 5'd11;
    localparam logic [4:0] ALU_BLT = 5'd12, ALU_BGE = 5'd13, ALU_BLTU = 5'd14, ALU_BGEU = 5'd15;
    localparam logic [4:0] ALU_PASSB = 5'd16;

    localparam logic [2:0] FT_R = 3'd0, FT_I = 3'd1, FT_S = 3'd2, FT_B = 3'd3, FT_U = 3'd4, FT_J = 3'd5;
    localparam logic [1:0] WB_ALU = 2'b00, WB_LOAD = 2'b01, WB_JAL = 2'b10, WB_NONE = 2'b11;

    localparam logic [6:0] OP_OP = 7'b0110011, OP_IMM = 7'b0010011, OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_FENCE = 7'b0001111, OP_SYSTEM = 7'b1110011;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        alt;
    logic [31:0] i_imm, s_imm, b_imm, j_imm, u_imm, sh_imm;
    logic [4:0]  arith_op;
    logic        is_illegal;

    assign opcode = IR[6:0];
    assign funct3 = IR[14:12];
    assign alt    = IR[30];

    assign i_imm  = {{20{IR[31]}}, IR[31:20]};
    assign s_imm  = {{20{IR[31]}}, IR[31:25], IR[11:7]};
    assign b_imm  = {{19{IR[31]}}, IR[31], IR[7], IR[30:25], IR[11:8], 1'b0};
    assign j_imm  = {{11{IR[31]}}, IR[31], IR[19:12], IR[20], IR[30:21], 1'b0};
    assign u_imm  = {IR[31:12], 12'b0};
    assign sh_imm = {27'b0, IR[24:20]};

    // Shared OP/OP-IMM funct3 mapping; the caller decides whether SUB is allowed.
    always_comb begin
        arith_op = ALU_ADD;
        case (funct3)
            3'b000: arith_op = ALU_ADD;
            3'b001: arith_op = ALU_SLL;
            3'b010: arith_op = ALU_SLT;
            3'b011: arith_op = ALU_SLTU;
            3'b100: arith_op = ALU_XOR;
            3'b101: arith_op = alt ? ALU_SRA : ALU_SRL;
            3'b110: arith_op = ALU_OR;
            default: arith_op = ALU_AND;
        endcase
    end

    // Every path starts from the NOP decode; illegal/FENCE/SYSTEM simply keep it.
    always_comb begin
        alu_instruction           = ALU_ADD;
        immediate_value           = 32'd0;
        instruction_format_type   = FT_I;
        write_back_type           = WB_NONE;
        read_status               = 2'b00;
        write_status              = 2'b00;
        load_signed               = 1'b0;
        pc_for_input_a            = 1'b0;
        change_branch_instruction = 1'b0;
        is_illegal                = 1'b0;
        case (opcode)
            OP_OP: begin
                instruction_format_type = FT_R;
                write_back_type         = WB_ALU;
                alu_instruction         = (funct3 == 3'b000 && alt) ? ALU_SUB : arith_op;
            end
            OP_IMM: begin
                write_back_type = WB_ALU;
                alu_instruction = arith_op;
                immediate_value = (funct3 == 3'b001 || funct3 == 3'b101) ? sh_imm : i_imm;
            end
            OP_LOAD: begin
                case (funct3)
                    3'b000: begin read_status = 2'b01; load_signed = 1'b1; end
                    3'b001: begin read_status = 2'b10; load_signed = 1'b1; end
                    3'b010: read_status = 2'b11;
                    3'b100: read_status = 2'b01;
                    3'b101: read_status = 2'b10;
                    default: is_illegal = 1'b1;
                endcase
                if (!is_illegal) begin
                    write_back_type = WB_LOAD;
                    immediate_value = i_imm;
                end
            end
            OP_STORE: begin
                case (funct3)
                    3'b000: write_status = 2'b01;
                    3'b001: write_status = 2'b10;
                    3'b010: write_status = 2'b11;
                    default: is_illegal = 1'b1;
                endcase
                if (!is_illegal) begin
                    instruction_format_type = FT_S;
                    immediate_value         = s_imm;
                end
            end
            OP_BRANCH: begin
                case (funct3)
                    3'b000: alu_instruction = ALU_BEQ;
                    3'b001: alu_instruction = ALU_BNE;
                    3'b100: alu_instruction = ALU_BLT;
                    3'b101: alu_instruction = ALU_BGE;
                    3'b110: alu_instruction = ALU_BLTU;
                    3'b111: alu_instruction = ALU_BGEU;
                    default: is_illegal = 1'b1;
                endcase
                if (!is_illegal) begin
                    instruction_format_type   = FT_B;
                    immediate_value           = b_imm;
                    change_branch_instruction = 1'b1;
                end
            end
            OP_JAL: begin
                instruction_format_type   = FT_J;
                write_back_type           = WB_JAL;
                immediate_value           = j_imm;
                pc_for_input_a            = 1'b1;
                change_branch_instruction = 1'b1;
            end
            OP_JALR: begin
                write_back_type           = WB_JAL;
                immediate_value           = i_imm;
                change_branch_instruction = 1'b1;
            end
            OP_LUI: begin
                instruction_format_type = FT_U;
                write_back_type         = WB_ALU;
                alu_instruction         = ALU_PASSB;
                immediate_value         = u_imm;
            end
            OP_AUIPC: begin
                instruction_format_type = FT_U;
                write_back_type         = WB_ALU;
                immediate_value         = u_imm;
                pc_for_input_a          = 1'b1;
            end
            OP_FENCE, OP_SYSTEM: ;
            default: is_illegal = 1'b1;
        endcase
    end

    assign destination_register_number = (write_back_type == WB_NONE) ? 5'd0 : IR[11:7];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            illegal_instruction <= 1'b0;
        else if (is_illegal)
            illegal_instruction <= 1'b1;
    end
endmodule

// File: tb/tb_rv32i_instruction_decoder.sv
// Scoreboard bench: stimulus queues hand-computed decodes, a monitor compares
// them on the falling edge; sticky-flag reset behaviour is checked inline.
module tb_rv32i_instruction_decoder;
    typedef struct packed {
        logic [4:0]  alu;
        logic [31:0] imm;
        logic [2:0]  ft;
        logic [1:0]  wb;
        logic [1:0]  rs;
        logic [1:0]  ws;
        logic        ls;
        logic [4:0]  rd;
        logic        pca;
        logic        cb;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] IR = 32'h00500093;
    logic [4:0]  alu_instruction;
    logic [31:0] immediate_value;
    logic [2:0]  instruction_format_type;
    logic [1:0]  write_back_type;
    logic [1:0]  read_status;
    logic [1:0]  write_status;
    logic        load_signed;
    logic [4:0]  destination_register_number;
    logic        pc_for_input_a;
    logic        change_branch_instruction;
    logic        illegal_instruction;

    int checks = 0;
    int errors = 0;
    exp_t q[$];
    logic [31:0] ir_q[$];
    logic sticky_model = 1'b0;
    logic prev_bad = 1'b0;

    rv32i_instruction_decoder dut (
        .clk(clk), .reset(reset), .IR(IR),
        .alu_instruction(alu_instruction),
        .immediate_value(immediate_value),
        .instruction_format_type(instruction_format_type),
        .write_back_type(write_back_type),
        .read_status(read_status),
        .write_status(write_status),
        .load_signed(load_signed),
        .destination_register_number(destination_register_number),
        .pc_for_input_a(pc_for_input_a),
        .change_branch_instruction(change_branch_instruction),
        .illegal_instruction(illegal_instruction)
    );

    always #5 clk = ~clk;

    task automatic vec(input logic [31:0] ir, input logic [4:0] alu, input logic [31:0] imm,
                       input logic [2:0] ft, input logic [1:0] wb, input logic [1:0] rs,
                       input logic [1:0] ws, input logic ls, input logic [4:0] rd,
                       input logic pca, input logic cb, input logic bad);
        exp_t e;
        @(posedge clk);
        sticky_model = sticky_model | prev_bad;
        #1;
        IR = ir;
        e = '{alu: alu, imm: imm, ft: ft, wb: wb, rs: rs, ws: ws, ls: ls, rd: rd,
              pca: pca, cb: cb, ill: sticky_model};
        q.push_back(e);
        ir_q.push_back(ir);
        prev_bad = bad;
    endtask

    task automatic nop(input logic [31:0] ir, input logic bad);
        vec(ir, 5'd0, 32'd0, 3'd1, 2'b11, 2'b00, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0, bad);
    endtask

    task automatic check_flag(input string name, input logic want);
        checks++;
        if (illegal_instruction !== want) begin
            errors++;
            $display("FAIL %s: illegal_instruction got %b want %b", name, illegal_instruction, want);
        end
    endtask

    // Clock the current (legal) IR, confirm the flag, then pull reset mid-cycle.
    task automatic async_reset(input string name);
        @(posedge clk);
        sticky_model = sticky_model | prev_bad;
        #1;
        check_flag({name, "_before"}, sticky_model);
        reset = 1'b0;
        #1;
        check_flag({name, "_async_clear"}, 1'b0);
        sticky_model = 1'b0;
        #1;
        reset = 1'b1;
    endtask

    initial begin : monitor
        exp_t e, a;
        logic [31:0] ir;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e  = q.pop_front();
                ir = ir_q.pop_front();
                a  = '{alu: alu_instruction, imm: immediate_value, ft: instruction_format_type,
                       wb: write_back_type, rs: read_status, ws: write_status, ls: load_signed,
                       rd: destination_register_number, pca: pc_for_input_a,
                       cb: change_branch_instruction, ill: illegal_instruction};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL decode IR=%h: got alu=%0d imm=%h ft=%0d wb=%b rs=%b ws=%b ls=%b rd=%0d pca=%b cb=%b ill=%b want alu=%0d imm=%h ft=%0d wb=%b rs=%b ws=%b ls=%b rd=%0d pca=%b cb=%b ill=%b",
                             ir, a.alu, a.imm, a.ft, a.wb, a.rs, a.ws, a.ls, a.rd, a.pca, a.cb, a.ill,
                             e.alu, e.imm, e.ft, e.wb, e.rs, e.ws, e.ls, e.rd, e.pca, e.cb, e.ill);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        #2;
        check_flag("reset_state", 1'b0);
        #10;
        reset = 1'b1;
        //        IR            alu    imm           ft    wb     rs     ws     ls    rd     pca   cb    bad
        vec(32'h00500093, 5'd0,  32'h00000005, 3'd1, 2'b00, 2'b00, 2'b00, 1'b0, 5'd1,  1'b0, 1'b0, 1'b0);
        vec(32'h40208133, 5'd1,  32'h00000000, 3'd0, 2'b00, 2'b00, 2'b00, 1'b0, 5'd2,  1'b0, 1'b0, 1'b0);
        vec(32'hFFC12183, 5'd0,  32'hFFFFFFFC, 3'd1, 2'b01, 2'b11, 2'b00, 1'b0, 5'd3,  1'b0, 1'b0, 1'b0);
        vec(32'hFE208EE3, 5'd10, 32'hFFFFFFFC, 3'd3, 2'b11, 2'b00, 2'b00, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0);
        vec(32'h008000EF, 5'd0,  32'h00000008, 3'd5, 2'b10, 2'b00, 2'b00, 1'b0, 5'd1,  1'b1, 1'b1, 1'b0);
        vec(32'h40335293, 5'd7,  32'h00000003, 3'd1, 2'b00, 2'b00, 2'b00, 1'b0, 5'd5,  1'b0, 1'b0, 1'b0);
        vec(32'hFFF47393, 5'd9,  32'hFFFFFFFF, 3'd1, 2'b00, 2'b00, 2'b00, 1'b0, 5'd7,  1'b0, 1'b0, 1'b0);
        vec(32'h40B554B3, 5'd7,  32'h00000000, 3'd0, 2'b00, 2'b00, 2'b00, 1'b0, 5'd9,  1'b0, 1'b0, 1'b0);
        vec(32'h003120B3, 5'd3,  32'h00000000, 3'd0, 2'b00, 2'b00, 2'b00, 1'b0, 5'd1,  1'b0, 1'b0, 1'b0);
        vec(32'h00128203, 5'd0,  32'h00000001, 3'd1, 2'b01, 2'b01, 2'b00, 1'b1, 5'd4,  1'b0, 1'b0, 1'b0);
        vec(32'hFFE3D303, 5'd0,  32'hFFFFFFFE, 3'd1, 2'b01, 2'b10, 2'b00, 1'b0, 5'd6,  1'b0, 1'b0, 1'b0);
        vec(32'hFE849D23, 5'd0,  32'hFFFFFFFA, 3'd2, 2'b11, 2'b00, 2'b10, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0);
        vec(32'h00112823, 5'd0,  32'h00000010, 3'd2, 2'b11, 2'b00, 2'b11, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0);
        vec(32'h0041F863, 5'd15, 32'h00000010, 3'd3, 2'b11, 2'b00, 2'b00, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0);
        vec(32'h004280E7, 5'd0,  32'h00000004, 3'd1, 2'b10, 2'b00, 2'b00, 1'b0, 5'd1,  1'b0, 1'b1, 1'b0);
        vec(32'h12345537, 5'd16, 32'h12345000, 3'd4, 2'b00, 2'b00, 2'b00, 1'b0, 5'd10, 1'b0, 1'b0, 1'b0);
        vec(32'hFFFFF597, 5'd0,  32'hFFFFF000, 3'd4, 2'b00, 2'b00, 2'b00, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0);
        nop(32'h0FF0000F, 1'b0);
        nop(32'h00000073, 1'b0);
        // All-zero word: NOP decode, flag rises after one edge and then holds.
        nop(32'h00000000, 1'b1);
        vec(32'h00500093, 5'd0,  32'h00000005, 3'd1, 2'b00, 2'b00, 2'b00, 1'b0, 5'd1,  1'b0, 1'b0, 1'b0);
        async_reset("zero_word");
        // Reserved funct3 in BRANCH, STORE and LOAD, each in isolation.
        nop(32'h00002063, 1'b1);
        vec(32'h00500093, 5'd0,  32'h00000005, 3'd1, 2'b00, 2'b00, 2'b00, 1'b0, 5'd1,  1'b0, 1'b0, 1'b0);
        async_reset("branch_f3");
        nop(32'h00003023, 1'b1);
        vec(32'h00500093, 5'd0,  32'h00000005, 3'd1, 2'b00, 2'b00, 2'b00, 1'b0, 5'd1,  1'b0, 1'b0, 1'b0);
        async_reset("store_f3");
        nop(32'h00013083, 1'b1);
        vec(32'h00500093, 5'd0,  32'h00000005, 3'd1, 2'b00, 2'b00, 2'b00, 1'b0, 5'd1,  1'b0, 1'b0, 1'b0);
        async_reset("load_f3");
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected results still queued, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
